// File: rtl/mac_accumulator.sv
// Accumulate stage behind the pipelined multiplier: sums ACC_LEN products per frame
// after a fixed warm-up, and holds each frame sum in a valid/ready output register.
module mac_accumulator #(
    parameter int PROD_W  = 6,
    parameter int ACC_LEN = 16,
    parameter int ACC_W   = 10,
    parameter int LAT     = 8,
    parameter int CNT_W   = $clog2(ACC_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_valid,
    input  logic              clear,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_valid,
    output logic              out_sat,
    output logic              overrun,
    output logic              running,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int WARM_W = (LAT > 2) ? $clog2(LAT) : 1;

    localparam logic [0:0] WARMUP = 1'b0;
    localparam logic [0:0] RUN    = 1'b1;

    localparam logic [ACC_W-1:0]  ACC_MAX   = '1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(ACC_LEN - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = (LAT > 0) ? WARM_W'(LAT - 1) : '0;

    logic [0:0]        state_q,     state_d;
    logic [WARM_W-1:0] warm_cnt_q,  warm_cnt_d;
    logic [ACC_W-1:0]  acc_q,       acc_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              sat_q,       sat_d;
    logic [ACC_W-1:0]  out_acc_q,   out_acc_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sat_q,   out_sat_d;
    logic              overrun_q,   overrun_d;

    logic [SUM_W-1:0]  sum;
    logic              sample_sat;
    logic [ACC_W-1:0]  sum_clamped;
    logic              is_final;

    // One spare bit on the adder exposes the carry used for saturation.
    assign sum         = {1'b0, acc_q} + SUM_W'(in_product);
    assign sample_sat  = (sum > {1'b0, ACC_MAX});
    assign sum_clamped = sample_sat ? ACC_MAX : sum[ACC_W-1:0];
    assign is_final    = (frame_cnt_q == LAST_CNT);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        acc_d       = acc_q;
        frame_cnt_d = frame_cnt_q;
        sat_d       = sat_q;
        out_acc_d   = out_acc_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;
        overrun_d   = overrun_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            WARMUP: begin
                if (LAT <= 1 || warm_cnt_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            default: begin
                if (clear) begin
                    acc_d       = '0;
                    frame_cnt_d = '0;
                    sat_d       = 1'b0;
                end else if (in_valid) begin
                    if (is_final) begin
                        // A final sample always wins the output register; an unread
                        // result is lost only if the consumer is not taking it now.
                        out_acc_d   = sum_clamped;
                        out_sat_d   = sat_q | sample_sat;
                        out_valid_d = 1'b1;
                        if (out_valid_q && !out_ready) begin
                            overrun_d = 1'b1;
                        end
                        acc_d       = '0;
                        frame_cnt_d = '0;
                        sat_d       = 1'b0;
                    end else begin
                        acc_d       = sum_clamped;
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        sat_d       = sat_q | sample_sat;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WARMUP;
            warm_cnt_q  <= '0;
            acc_q       <= '0;
            frame_cnt_q <= '0;
            sat_q       <= 1'b0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            acc_q       <= acc_d;
            frame_cnt_q <= frame_cnt_d;
            sat_q       <= sat_d;
            out_acc_q   <= out_acc_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_acc   = out_acc_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;
    assign overrun   = overrun_q;
    assign running   = (state_q == RUN);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: two instances (10-bit and 9-bit sums) share the
// stimulus; a frame-level model is compared every cycle, plus hand-computed literals.
module tb_mac_accumulator;

    localparam int PROD_W  = 6;
    localparam int ACC_LEN = 16;
    localparam int LAT     = 8;
    localparam int CNT_W   = 4;
    localparam int MAX10   = 1023;
    localparam int MAX9    = 511;

    logic              clk;
    logic              reset;
    logic [PROD_W-1:0] in_product;
    logic              in_valid;
    logic              clear;
    logic              out_ready;

    logic [9:0]        out_acc;
    logic              out_valid, out_sat, overrun, running;
    logic [CNT_W-1:0]  frame_cnt;

    logic [8:0]        out_acc9;
    logic              out_valid9, out_sat9, overrun9, running9;
    logic [CNT_W-1:0]  frame_cnt9;

    mac_accumulator #(.PROD_W(PROD_W), .ACC_LEN(ACC_LEN), .ACC_W(10), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .in_product(in_product), .in_valid(in_valid),
        .clear(clear), .out_ready(out_ready), .out_acc(out_acc), .out_valid(out_valid),
        .out_sat(out_sat), .overrun(overrun), .running(running), .frame_cnt(frame_cnt)
    );

    mac_accumulator #(.PROD_W(PROD_W), .ACC_LEN(ACC_LEN), .ACC_W(9), .LAT(LAT)) dut9 (
        .clk(clk), .reset(reset), .in_product(in_product), .in_valid(in_valid),
        .clear(clear), .out_ready(out_ready), .out_acc(out_acc9), .out_valid(out_valid9),
        .out_sat(out_sat9), .overrun(overrun9), .running(running9), .frame_cnt(frame_cnt9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: running total of the frame, clamped only when the frame closes.
    int m_since, m_cnt, m_total, m_acc10, m_acc9;
    bit m_run, m_valid, m_over, m_sat10, m_sat9;

    task automatic model_step();
        bit consume;
        bit fin;
        if (reset) begin
            m_since = 0; m_run = 0; m_cnt = 0; m_total = 0;
            m_valid = 0; m_over = 0; m_acc10 = 0; m_acc9 = 0; m_sat10 = 0; m_sat9 = 0;
        end else begin
            consume = m_valid && out_ready;
            fin     = 1'b0;
            if (!m_run) begin
                m_since++;
                if (m_since >= LAT) m_run = 1'b1;
            end else if (clear) begin
                m_cnt   = 0;
                m_total = 0;
            end else if (in_valid) begin
                m_total += int'(in_product);
                m_cnt++;
                if (m_cnt == ACC_LEN) fin = 1'b1;
            end
            if (fin) begin
                if (m_valid && !out_ready) m_over = 1'b1;
                m_acc10 = (m_total > MAX10) ? MAX10 : m_total;
                m_sat10 = (m_total > MAX10);
                m_acc9  = (m_total > MAX9) ? MAX9 : m_total;
                m_sat9  = (m_total > MAX9);
                m_valid = 1'b1;
                m_cnt   = 0;
                m_total = 0;
            end else if (consume) begin
                m_valid = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("running",    running,    m_run);
            check("frame_cnt",  frame_cnt,  m_cnt);
            check("out_valid",  out_valid,  m_valid);
            check("overrun",    overrun,    m_over);
            check("out_acc",    out_acc,    m_acc10);
            check("out_sat",    out_sat,    m_sat10);
            check("out_acc9",   out_acc9,   m_acc9);
            check("out_sat9",   out_sat9,   m_sat9);
            check("out_valid9", out_valid9, m_valid);
            check("overrun9",   overrun9,   m_over);
        end
    end

    // Inputs change only after a falling edge, so the model sees what the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic feed(input int val, input int n);
        in_valid   = 1'b1;
        in_product = PROD_W'(val);
        repeat (n) tick();
    endtask

    task automatic count_to_running(output int k);
        k = 0;
        while (!running && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic restart();
        int k;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        count_to_running(k);
        check("restart_running", running, 1);
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_product = '0;
        clear      = 1'b0;
        out_ready  = 1'b0;

        // 1: warm-up timing with constant product 1
        tick();
        chk_en = 1'b1;
        tick();
        check("t1_rst_running", running, 0);
        check("t1_rst_valid", out_valid, 0);
        check("t1_rst_acc", out_acc, 0);
        check("t1_rst_cnt", frame_cnt, 0);
        reset      = 1'b0;
        in_valid   = 1'b1;
        in_product = 6'd1;
        count_to_running(k);
        check("t1_warmup_cycles", k, 8);
        k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        check("t1_first_frame_cycles", k, 16);
        check("t1_out_acc", out_acc, 16);

        // 2: plain frame sum, held until consumed
        restart();
        feed(36, 16);
        in_valid = 1'b0;
        check("t2_valid", out_valid, 1);
        check("t2_acc", out_acc, 576);
        check("t2_sat", out_sat, 0);
        check("t2_acc9", out_acc9, 511);
        repeat (3) tick();
        check("t2_hold_acc", out_acc, 576);
        check("t2_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_consumed", out_valid, 0);

        // 3: overrun, then the same with a consume on the final cycle
        restart();
        feed(3, 16);
        feed(5, 16);
        check("t3_acc", out_acc, 80);
        check("t3_overrun", overrun, 1);
        restart();
        feed(3, 16);
        feed(5, 15);
        out_ready = 1'b1;
        feed(5, 1);
        out_ready = 1'b0;
        check("t3b_acc", out_acc, 80);
        check("t3b_valid", out_valid, 1);
        check("t3b_overrun", overrun, 0);

        // 4: clear drops the partial frame and the simultaneous product
        restart();
        feed(7, 5);
        check("t4_cnt_before", frame_cnt, 5);
        clear = 1'b1;
        feed(7, 1);
        clear = 1'b0;
        check("t4_cnt_cleared", frame_cnt, 0);
        feed(2, 16);
        in_valid = 1'b0;
        check("t4_acc", out_acc, 32);

        // 5: saturation on the 9-bit instance, then a clean frame
        restart();
        feed(49, 16);
        check("t5_acc9", out_acc9, 511);
        check("t5_sat9", out_sat9, 1);
        check("t5_acc10", out_acc, 784);
        feed(1, 16);
        in_valid = 1'b0;
        check("t5b_acc9", out_acc9, 16);
        check("t5b_sat9", out_sat9, 0);

        // 6: reset mid-frame with a result pending
        restart();
        feed(4, 16);
        feed(4, 9);
        check("t6_pending", out_valid, 1);
        check("t6_cnt", frame_cnt, 9);
        reset = 1'b1;
        tick();
        check("t6_rst_acc", out_acc, 0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_running", running, 0);
        check("t6_rst_cnt", frame_cnt, 0);
        reset = 1'b0;
        feed(3, 0);
        count_to_running(k);
        check("t6_warmup_cycles", k, 8);
        feed(3, 16);
        in_valid = 1'b0;
        check("t6_acc", out_acc, 48);
        check("t6_valid", out_valid, 1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream accumulate stage for the pipelined 3x3 multiplier; completes the "AC" half of the MAC.
- Consumes the 6-bit product stream P5..P0 and sums ACC_LEN products per frame.
- Skips the multiplier's pipeline-fill cycles after reset.
- Presents each frame sum through a valid/ready output register, for capture by the ILA or a downstream consumer.

Parameters:
- PROD_W, 6: product input width.
- ACC_LEN, 16: products per frame; matches the 16-entry operand BRAM sweep. Must be >= 2.
- ACC_W, 10: accumulator/result width. The 10-bit default fits 16 x 49 = 784.
- LAT, 8: cycles after reset release during which in_valid is ignored. Covers 1 BRAM read cycle plus 7 multiplier stages.
- CNT_W, clog2(ACC_LEN): derived, frame counter width.

Ports:
- clk  in  1  single clock; all logic is on posedge.
- reset  in  1  synchronous, active-high.
- in_product  in  PROD_W  product from the multiplier.
- in_valid  in  1  product qualifier; tie to 1 for the free-running multiplier.
- clear  in  1  synchronous frame abort; zeroes the running accumulator and counter.
- out_ready  in  1  consumer accepts out_acc.
- out_acc  out  ACC_W  registered frame sum.
- out_valid  out  1  out_acc holds an unconsumed frame sum.
- out_sat  out  1  the frame in out_acc saturated.
- overrun  out  1  sticky; a completed frame overwrote an unconsumed one.
- running  out  1  warm-up finished; products are being sampled.
- frame_cnt  out  CNT_W  products accumulated in the current frame.

Behaviour:
- Reset values (reset=1 at a posedge):
  - acc, frame_cnt, out_acc, out_valid, out_sat, overrun, running and the warm-up counter all 0.
  - Reset has priority over every other input.
  - Reset mid-frame discards all state and restarts warm-up.
- States: WARMUP and RUN.
  - WARMUP: counter increments each cycle; in_valid is ignored. On the cycle the counter reaches LAT-1, go to RUN and set running=1 next cycle.
  - LAT=0 enters RUN directly after reset.
  - RUN is left only by reset.
- A sample occurs in RUN when in_valid=1 and clear=0.
  - sum = acc + zero-extended in_product, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1, it clamps to 2^ACC_W-1 and a per-frame sat flag is set. The sat flag clears at frame start.
  - Once saturated, the accumulator stays at max for the rest of the frame.
- Non-final sample (frame_cnt < ACC_LEN-1): acc <= sum, frame_cnt++.
- Final sample (frame_cnt = ACC_LEN-1):
  - out_acc <= sum; out_sat <= frame sat flag OR this sample's saturation; out_valid <= 1.
  - acc <= 0, frame_cnt <= 0, sat flag <= 0.
  - Latency: the result is visible the cycle after the final sample.
- Output handshake:
  - out_valid & out_ready at a posedge clears out_valid, unless a final sample occurs in the same cycle. In that case out_valid stays 1 with the new data and there is no overrun.
  - A final sample while out_valid=1 and out_ready=0 overwrites out_acc/out_sat and sets overrun=1. overrun clears only on reset.
- The multiplier cannot stall: accumulation never backpressures, and the next frame starts immediately regardless of out_ready.
- clear=1 in RUN:
  - acc <= 0, frame_cnt <= 0, sat flag <= 0; any simultaneous in_valid product is dropped.
  - out_acc, out_valid, out_sat and overrun are unaffected.
  - In WARMUP, clear has no effect.
- Data are unsigned throughout; products are never sign-extended.

Test Plan:
1. Warm-up: reset for 2 cycles, then in_valid=1 with in_product=1 constant.
   - running rises 8 cycles after reset release.
   - out_valid rises 16 cycles after running with out_acc=16.
2. Frame sum: 16 valid products of 36 with out_ready=0.
   - out_acc=576, out_sat=0, out_valid=1 one cycle after the 16th sample.
   - Values hold until out_ready=1 for one cycle, after which out_valid=0.
3. Overrun: two back-to-back frames of products 3 then 5, out_ready=0 throughout.
   - After frame 2: out_acc=80, overrun=1.
   - Repeat with out_ready=1 pulsed exactly on frame 2's final cycle: out_acc=80, out_valid=1, overrun=0.
4. Clear: 5 products of 7, then clear=1 with in_valid=1 and product 7, then 16 products of 2.
   - out_acc=32; frame_cnt=0 the cycle after clear.
5. Saturation: ACC_W=9, 16 products of 49.
   - out_acc=511, out_sat=1.
   - The following frame of 16 x 1 gives out_acc=16, out_sat=0.
6. Reset mid-frame: assert reset after 9 products with out_valid=1 pending.
   - All outputs 0 next cycle.
   - Warm-up repeats (running=0 for 8 cycles), and the next frame sum counts only post-warm-up products.
